tm_tape_cache: RTL and testbench
================================

# tm_tape_cache

Head-side tape cache for the Turing machine core. It holds the symbol under the head and one predicted neighbour cell, fetched ahead of use from external tape memory. It sits between the core's control FSM and the tape memory port, and consumes the predictor's `pred_r`/`pred_l` outputs. This is the read/write end of the interface whose direction history the predictor observes.

## Interface
- `ADDR_BITS`, default 8: tape address width; the tape is a ring of 2^ADDR_BITS cells.
- `SYM_BITS`, default 2: symbol width.
- `clk`  in  1  clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `move_i`  in  1  head moves this cycle; accepted only when `ready_o` is 1.
- `dir_i`  in  1  move direction; 1 is right (+1), 0 is left (−1).
- `wr_en_i`  in  1  write `wr_sym_i` into the head cell; accepted only when `ready_o` is 1.
- `wr_sym_i`  in  SYM_BITS  symbol to write.
- `pred_r_i` / `pred_l_i`  in  1  predictor says next move is right / left.
- `ready_o`  out  1  head cell is valid and no writeback is pending.
- `sym_o`  out  SYM_BITS  symbol under the head; meaningful only when `ready_o` is 1.
- `pos_o`  out  ADDR_BITS  head address.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  request is a write.
- `mem_addr_o`  out  ADDR_BITS  request address.
- `mem_wdata_o`  out  SYM_BITS  write data.
- `mem_rdata_i`  in  SYM_BITS  read data; valid in the cycle `mem_ack_i` is high.
- `mem_ack_i`  in  1  request completes this cycle.

## Operation
- State held:
  - `pos`
  - head cell: `cur_valid`, `cur_sym`, `cur_dirty`
  - prefetch slot: `pf_valid`, `pf_dir`, `pf_sym`
  - writeback buffer: `wb_valid`, `wb_addr`, `wb_sym`
  - `stale` flag
- `ready_o = cur_valid & ~wb_valid`.
- Write: when `wr_en_i & ready_o`, `cur_sym` takes `wr_sym_i` and `cur_dirty` is set.
- Write and move in the same cycle: the write lands on the old cell, and that cell is then written back.
- Accepted move, general rules:
  - `pos` takes `pos ± 1` modulo 2^ADDR_BITS.
  - If the old cell is dirty, it goes to the writeback buffer.
- Accepted move, hit (`pf_valid` and `pf_dir == dir_i`): `cur_sym` takes `pf_sym`, `cur_dirty` clears, and `cur_valid` stays 1.
- Accepted move, miss: `cur_valid` clears.
- `pf_valid` clears on every accepted move.
- FSM states are IDLE, WB, FETCH_CUR and FETCH_PF. IDLE issues work in this priority order:
  1. `wb_valid` → WB.
  2. `~cur_valid` → FETCH_CUR at `pos`.
  3. `(pred_r_i | pred_l_i) & ~pf_valid` → FETCH_PF at `pos+1` if `pred_r_i`, else `pos−1`. `pf_dir` is latched.
- On ack:
  - WB → clear `wb_valid`.
  - FETCH_CUR → fill the head cell.
  - FETCH_PF → fill the slot, unless `stale`.
  - Every ack returns the FSM to IDLE.
- Move during FETCH_PF in the same direction as `pf_dir`: the in-flight read becomes the head fetch. Its ack fills `cur_sym`, and `pf_valid` stays 0.
- Move during FETCH_PF in the opposite direction: set `stale`. The ack is discarded and `stale` clears.
- Address wrap: `pos` 2^ADDR_BITS−1 plus a right move gives 0. Prefetch address arithmetic is modulo 2^ADDR_BITS.
- `move_i` and `wr_en_i` are ignored while `ready_o` is 0.

## Timing
- Reset values:
  - `ready_o` = 0, `sym_o` = 0, `pos_o` = 0.
  - `mem_req_o` = 0, `mem_we_o` = 0, `mem_addr_o` = 0, `mem_wdata_o` = 0.
  - FSM = IDLE; all valid, dirty and stale bits = 0.
- Reset is asserted asynchronously. After release, the first cycle enters FETCH_CUR at address 0.
- Request outputs are registered. The request is raised the cycle after the FSM leaves IDLE.
- `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are held stable until the ack cycle. `mem_req_o` is 0 in the cycle after the ack.
- The earliest ack is in the first request cycle.
- Hit with a clean old cell: move at cycle t, then `ready_o` = 1 and `sym_o` = the new cell at t+1.
- Miss, or dirty old cell: `ready_o` falls at t+1. It returns the cycle after the last required ack.
- A reset mid-transaction drops `mem_req_o` immediately and discards all state.

## Structure
- Shared include `tm_defs.vh`:
  - `TM_SYM_BITS`
  - `TM_ADDR_BITS`
  - FSM state encodings: IDLE=0, WB=1, FETCH_CUR=2, FETCH_PF=3
  - direction constants `TM_DIR_R=1`, `TM_DIR_L=0`
- No sub-module. The FSM and datapath are inline. The parent wires `tm_tape_pred` onto `move_i`/`dir_i` and into `pred_*_i`.

## Test plan
- Reset release with memory cell 0 = 2 and 1-cycle ack → `mem_req_o` read at address 0, then `ready_o` = 1 and `sym_o` = 2.
- `pred_r_i` = 1 with cell 1 = 3 → FETCH_PF read at address 1. Then move right → at t+1 `ready_o` stays 1, `sym_o` = 3, `pos_o` = 1, and no memory request is issued.
- Write 1 plus move left in the same cycle at `pos` 1 → WB write of address 1, data 1, then FETCH_CUR read of address 0. `ready_o` stays low until the read ack.
- Prefetch right in flight (ack delayed 5 cycles), then move left → the ack data is discarded, `pf_valid` = 0, and the next read targets address `pos−1`.
- `pos` = 255 (ADDR_BITS = 8), `pred_r_i` = 1 → prefetch address is 0. After moving right, `pos_o` = 0.
- Assert `rst` while `mem_req_o` is high → `mem_req_o` = 0 in the same cycle, and after release a fresh fetch at address 0.

Source files
------------

// File: rtl/tm_tape_cache_pkg.sv
// Shared types and constants for the Turing machine tape cache.
// FSM encodings and direction values match the legacy tm_defs.vh include.
package tm_tape_cache_pkg;

    localparam int unsigned TM_SYM_BITS  = 2;
    localparam int unsigned TM_ADDR_BITS = 8;

    localparam logic TM_DIR_R = 1'b1;
    localparam logic TM_DIR_L = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WB        = 2'd1,
        ST_FETCH_CUR = 2'd2,
        ST_FETCH_PF  = 2'd3
    } state_e;

endpackage

// File: rtl/tm_tape_cache.sv
// Head-side tape cache: head cell, one predicted neighbour and a single
// writeback buffer in front of the external tape memory port.
module tm_tape_cache
    import tm_tape_cache_pkg::*;
#(
    parameter int unsigned ADDR_BITS = TM_ADDR_BITS,
    parameter int unsigned SYM_BITS  = TM_SYM_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 move_i,
    input  logic                 dir_i,
    input  logic                 wr_en_i,
    input  logic [SYM_BITS-1:0]  wr_sym_i,
    input  logic                 pred_r_i,
    input  logic                 pred_l_i,
    output logic                 ready_o,
    output logic [SYM_BITS-1:0]  sym_o,
    output logic [ADDR_BITS-1:0] pos_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [SYM_BITS-1:0]  mem_wdata_o,
    input  logic [SYM_BITS-1:0]  mem_rdata_i,
    input  logic                 mem_ack_i
);

    state_e state_q, state_d;

    logic [ADDR_BITS-1:0] pos_q, pos_d;
    logic                 cur_valid_q, cur_valid_d;
    logic [SYM_BITS-1:0]  cur_sym_q, cur_sym_d;
    logic                 cur_dirty_q, cur_dirty_d;
    logic                 pf_valid_q, pf_valid_d;
    logic                 pf_dir_q, pf_dir_d;
    logic [SYM_BITS-1:0]  pf_sym_q, pf_sym_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [ADDR_BITS-1:0] wb_addr_q, wb_addr_d;
    logic [SYM_BITS-1:0]  wb_sym_q, wb_sym_d;
    logic                 stale_q, stale_d;
    logic                 promote_q, promote_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [SYM_BITS-1:0]  wdata_q, wdata_d;

    logic                 ready;
    logic                 move_acc;
    logic                 wr_acc;
    logic                 pf_issue;
    logic [ADDR_BITS-1:0] pos_next;
    logic [ADDR_BITS-1:0] pf_addr;

    assign ready    = cur_valid_q & ~wb_valid_q;
    assign move_acc = move_i & ready;
    assign wr_acc   = wr_en_i & ready;
    assign pos_next = (dir_i == TM_DIR_R) ? pos_q + 1'b1 : pos_q - 1'b1;
    assign pf_addr  = pred_r_i ? pos_q + 1'b1 : pos_q - 1'b1;
    // No prefetch is launched in a move cycle: the target would be relative to the old head.
    assign pf_issue = (pred_r_i | pred_l_i) & ~pf_valid_q & ~move_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wb_valid_q)       state_d = ST_WB;
                else if (!cur_valid_q) state_d = ST_FETCH_CUR;
                else if (pf_issue)    state_d = ST_FETCH_PF;
            end
            default: begin
                if (mem_ack_i) state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_q == ST_IDLE) begin
            case (state_d)
                ST_WB: begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = wb_addr_q;
                    wdata_d = wb_sym_q;
                end
                ST_FETCH_CUR: begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pos_q;
                end
                ST_FETCH_PF: begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pf_addr;
                end
                default: ;
            endcase
        end else if (mem_ack_i) begin
            req_d = 1'b0;
        end
    end

    always_comb begin
        pos_d       = pos_q;
        cur_valid_d = cur_valid_q;
        cur_sym_d   = cur_sym_q;
        cur_dirty_d = cur_dirty_q;
        pf_valid_d  = pf_valid_q;
        pf_dir_d    = pf_dir_q;
        pf_sym_d    = pf_sym_q;
        wb_valid_d  = wb_valid_q;
        wb_addr_d   = wb_addr_q;
        wb_sym_d    = wb_sym_q;
        stale_d     = stale_q;
        promote_d   = promote_q;

        if (wr_acc) begin
            cur_sym_d   = wr_sym_i;
            cur_dirty_d = 1'b1;
        end

        if (move_acc) begin
            pos_d      = pos_next;
            pf_valid_d = 1'b0;
            if (cur_dirty_q | wr_acc) begin
                wb_valid_d = 1'b1;
                wb_addr_d  = pos_q;
                wb_sym_d   = wr_acc ? wr_sym_i : cur_sym_q;
            end
            if (pf_valid_q && (pf_dir_q == dir_i)) begin
                cur_sym_d   = pf_sym_q;
                cur_dirty_d = 1'b0;
            end else begin
                cur_valid_d = 1'b0;
                cur_dirty_d = 1'b0;
            end
            // A prefetch still in flight either becomes the head fetch or is poisoned.
            if (state_q == ST_FETCH_PF && !mem_ack_i) begin
                if (dir_i == pf_dir_q) promote_d = 1'b1;
                else                   stale_d   = 1'b1;
            end
        end

        if (state_q == ST_IDLE && state_d == ST_FETCH_PF) begin
            pf_dir_d = pred_r_i ? TM_DIR_R : TM_DIR_L;
        end

        if (state_q == ST_WB && mem_ack_i) begin
            wb_valid_d = 1'b0;
        end

        if (state_q == ST_FETCH_CUR && mem_ack_i) begin
            cur_valid_d = 1'b1;
            cur_sym_d   = mem_rdata_i;
            cur_dirty_d = 1'b0;
        end

        if (state_q == ST_FETCH_PF && mem_ack_i) begin
            stale_d   = 1'b0;
            promote_d = 1'b0;
            if (promote_q || (move_acc && dir_i == pf_dir_q)) begin
                cur_valid_d = 1'b1;
                cur_sym_d   = mem_rdata_i;
                cur_dirty_d = 1'b0;
            end else if (!stale_q && !move_acc) begin
                pf_valid_d = 1'b1;
                pf_sym_d   = mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q       <= '0;
            cur_valid_q <= 1'b0;
            cur_sym_q   <= '0;
            cur_dirty_q <= 1'b0;
            pf_valid_q  <= 1'b0;
            pf_dir_q    <= 1'b0;
            pf_sym_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_sym_q    <= '0;
            stale_q     <= 1'b0;
            promote_q   <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            pos_q       <= pos_d;
            cur_valid_q <= cur_valid_d;
            cur_sym_q   <= cur_sym_d;
            cur_dirty_q <= cur_dirty_d;
            pf_valid_q  <= pf_valid_d;
            pf_dir_q    <= pf_dir_d;
            pf_sym_q    <= pf_sym_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_sym_q    <= wb_sym_d;
            stale_q     <= stale_d;
            promote_q   <= promote_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign ready_o     = ready;
    assign sym_o       = cur_sym_q;
    assign pos_o       = pos_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_tm_tape_cache.sv
// Directed and randomized bench for tm_tape_cache against a flat tape model
// and a latency-programmable memory responder.
module tb_tm_tape_cache;

    localparam int unsigned AB = 8;
    localparam int unsigned SB = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          move_i = 1'b0;
    logic          dir_i = 1'b0;
    logic          wr_en_i = 1'b0;
    logic [SB-1:0] wr_sym_i = '0;
    logic          pred_r_i = 1'b0;
    logic          pred_l_i = 1'b0;
    logic          ready_o;
    logic [SB-1:0] sym_o;
    logic [AB-1:0] pos_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AB-1:0] mem_addr_o;
    logic [SB-1:0] mem_wdata_o;
    logic [SB-1:0] mem_rdata_i = '0;
    logic          mem_ack_i = 1'b0;

    logic [SB-1:0] mem  [256];
    logic [SB-1:0] tape [256];
    int lat = 0;
    int cnt = 0;
    int total = 0;
    int bad = 0;

    tm_tape_cache #(.ADDR_BITS(AB), .SYM_BITS(SB)) dut (
        .clk(clk), .rst(rst), .move_i(move_i), .dir_i(dir_i),
        .wr_en_i(wr_en_i), .wr_sym_i(wr_sym_i),
        .pred_r_i(pred_r_i), .pred_l_i(pred_l_i),
        .ready_o(ready_o), .sym_o(sym_o), .pos_o(pos_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    // Memory acks after 'lat' waiting cycles; ack is held across one rising edge.
    always @(negedge clk) begin
        if (mem_req_o) begin
            if (cnt >= lat) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem[mem_addr_o];
                if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
                cnt = 0;
            end else begin
                mem_ack_i = 1'b0;
                cnt++;
            end
        end else begin
            mem_ack_i = 1'b0;
            cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready_o && n < 60) begin
            step();
            n++;
        end
        chk(tag, ready_o, 1);
    endtask

    initial begin
        logic [AB-1:0] mpos;
        int stuck;
        int mism;
        logic mv, dr, wr;
        logic [SB-1:0] ws;

        for (int i = 0; i < 256; i++) mem[i] = SB'($urandom_range(0, 3));
        mem[0]   = 2'd2;
        mem[1]   = 2'd3;
        mem[255] = 2'd3;

        // Reset state
        step();
        step();
        chk("rst_ready", ready_o, 0);
        chk("rst_sym", sym_o, 0);
        chk("rst_pos", pos_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        rst = 1'b0;

        // First fetch of cell 0
        step();
        chk("boot_req", mem_req_o, 1);
        chk("boot_we", mem_we_o, 0);
        chk("boot_addr", mem_addr_o, 0);
        step();
        chk("boot_ready", ready_o, 1);
        chk("boot_sym", sym_o, 2);
        chk("boot_req_drop", mem_req_o, 0);

        // Prefetch right then hit
        pred_r_i = 1'b1;
        step();
        chk("pf_req", mem_req_o, 1);
        chk("pf_addr", mem_addr_o, 1);
        chk("pf_we", mem_we_o, 0);
        step();
        move_i = 1'b1;
        dir_i  = 1'b1;
        step();
        move_i = 1'b0;
        pred_r_i = 1'b0;
        chk("hit_ready", ready_o, 1);
        chk("hit_sym", sym_o, 3);
        chk("hit_pos", pos_o, 1);
        chk("hit_noreq", mem_req_o, 0);

        // Write + move left: writeback then miss fetch
        wr_en_i  = 1'b1;
        wr_sym_i = 2'd1;
        move_i   = 1'b1;
        dir_i    = 1'b0;
        step();
        wr_en_i = 1'b0;
        move_i  = 1'b0;
        chk("wm_ready", ready_o, 0);
        chk("wm_pos", pos_o, 0);
        step();
        chk("wb_req", mem_req_o, 1);
        chk("wb_we", mem_we_o, 1);
        chk("wb_addr", mem_addr_o, 1);
        chk("wb_wdata", mem_wdata_o, 1);
        step();
        chk("wb_ready_low", ready_o, 0);
        step();
        chk("fc_req", mem_req_o, 1);
        chk("fc_we", mem_we_o, 0);
        chk("fc_addr", mem_addr_o, 0);
        step();
        chk("fc_ready", ready_o, 1);
        chk("fc_sym", sym_o, 2);
        chk("wb_mem", mem[1], 1);

        // Prefetch right in flight, move left -> stale discard
        lat = 5;
        pred_r_i = 1'b1;
        step();
        chk("st_pf_addr", mem_addr_o, 1);
        move_i = 1'b1;
        dir_i  = 1'b0;
        step();
        move_i = 1'b0;
        pred_r_i = 1'b0;
        chk("st_pos", pos_o, 255);
        chk("st_ready", ready_o, 0);
        chk("st_req_held", mem_req_o, 1);
        begin
            int n = 0;
            while (mem_req_o && n < 20) begin
                step();
                n++;
            end
        end
        chk("st_ack_seen", mem_req_o, 0);
        lat = 0;
        step();
        chk("st_refetch_req", mem_req_o, 1);
        chk("st_refetch_addr", mem_addr_o, 255);
        step();
        chk("st_ready_back", ready_o, 1);
        chk("st_sym", sym_o, 3);

        // Wrap: prefetch right from 255 targets 0
        pred_r_i = 1'b1;
        step();
        chk("wrap_pf_req", mem_req_o, 1);
        chk("wrap_pf_addr", mem_addr_o, 0);
        step();
        pred_r_i = 1'b0;
        move_i = 1'b1;
        dir_i  = 1'b1;
        step();
        move_i = 1'b0;
        chk("wrap_pos", pos_o, 0);
        chk("wrap_ready", ready_o, 1);
        chk("wrap_sym", sym_o, 2);

        // Reset during an outstanding request
        lat = 10;
        pred_r_i = 1'b1;
        step();
        pred_r_i = 1'b0;
        chk("mr_req_before", mem_req_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("mr_req_drop", mem_req_o, 0);
        chk("mr_ready_drop", ready_o, 0);
        step();
        rst = 1'b0;
        lat = 0;
        step();
        chk("mr_fetch_req", mem_req_o, 1);
        chk("mr_fetch_addr", mem_addr_o, 0);
        step();
        chk("mr_ready", ready_o, 1);
        chk("mr_sym", sym_o, 2);

        // Randomized phase against the flat tape model
        for (int i = 0; i < 256; i++) tape[i] = mem[i];
        mpos = '0;
        stuck = 0;
        for (int it = 0; it < 3000; it++) begin
            @(negedge clk);
            if (ready_o) begin
                chk("rnd_sym", sym_o, tape[mpos]);
                chk("rnd_pos", pos_o, mpos);
                stuck = 0;
            end else begin
                stuck++;
                if (stuck > 80) begin
                    total++;
                    bad++;
                    $error("FAIL rnd_ready_timeout observed=%0d expected<=80", stuck);
                    break;
                end
            end
            mv = ($urandom_range(0, 2) == 0);
            dr = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 3) == 0);
            ws = SB'($urandom_range(0, 3));
            move_i   = mv;
            dir_i    = dr;
            wr_en_i  = wr;
            wr_sym_i = ws;
            pred_r_i = ($urandom_range(0, 2) == 0);
            pred_l_i = ($urandom_range(0, 2) == 0);
            lat      = $urandom_range(0, 3);
            if (ready_o) begin
                if (wr) tape[mpos] = ws;
                if (mv) mpos = dr ? mpos + 8'd1 : mpos - 8'd1;
            end
        end

        // Everything left behind by the head must have reached memory
        @(negedge clk);
        move_i = 1'b0;
        wr_en_i = 1'b0;
        pred_r_i = 1'b0;
        pred_l_i = 1'b0;
        step();
        wait_ready("final_ready");
        chk("final_pos", pos_o, mpos);
        mism = 0;
        for (int i = 0; i < 256; i++) begin
            if (AB'(i) != mpos && mem[i] !== tape[i]) mism++;
        end
        chk("final_mem", mism, 0);
        chk("final_sym", sym_o, tape[mpos]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
